// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU: opcode and funct encodings
// of the supported MIPS-style subset, the ALU operation select and the
// control FSM state encoding.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam int NUM_REGS = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_sel_e;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

endpackage

// File: rtl/cpu_regfile.sv
// 32-entry general-purpose register file.
// Ports: clk_i, rst_ni (async active-low, clears all entries),
//        raddr1_i/rdata1_o and raddr2_i/rdata2_o (combinational reads),
//        we_i/waddr_i/wdata_i (write on rising clock edge).
// Register 0 always reads zero and ignores writes.
module cpu_regfile
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [4:0]      raddr1_i,
    input  logic [4:0]      raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = (raddr1_i == 5'd0) ? '0 : regs_q[raddr1_i];
    assign rdata2_o = (raddr2_i == 5'd0) ? '0 : regs_q[raddr2_i];

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle CPU top for a MIPS-style subset (add/sub/and/or/slt, addi,
// lw, sw, beq, j) with req/ack handshakes toward instruction and data
// memory.
// Ports: clk, rst (async active-low);
//        instr_addr/instr_req/instr/instr_ack  - instruction fetch;
//        data_addr/data_out/data_in/mem_read/mem_write/data_ack - data access;
//        retire - 1-cycle pulse per completed instruction;
//        illegal_instr - 1-cycle pulse per undecodable instruction.
// ADDR_W must not exceed XLEN (data_addr is taken from the ALU result).
module cpu_multicycle
    import cpu_pkg::*;
#(
    parameter int                XLEN     = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              instr_req,
    input  logic [31:0]       instr,
    input  logic              instr_ack,
    output logic [ADDR_W-1:0] data_addr,
    output logic [XLEN-1:0]   data_out,
    input  logic [XLEN-1:0]   data_in,
    output logic              mem_read,
    output logic              mem_write,
    input  logic              data_ack,
    output logic              retire,
    output logic              illegal_instr
);

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       ir_q;
    logic [XLEN-1:0]   a_q, b_q, imm_q, alu_q, mdr_q;
    logic              instr_req_q, mem_read_q, mem_write_q;
    logic [ADDR_W-1:0] data_addr_q;
    logic [XLEN-1:0]   data_out_q;
    logic              retire_q, illegal_q;

    // Decoder
    logic     dec_r, dec_addi, dec_lw, dec_sw, dec_beq, dec_j, dec_legal;
    alu_sel_e dec_alu;

    always_comb begin
        dec_r    = 1'b0;
        dec_addi = 1'b0;
        dec_lw   = 1'b0;
        dec_sw   = 1'b0;
        dec_beq  = 1'b0;
        dec_j    = 1'b0;
        dec_alu  = ALU_ADD;
        case (ir_q[31:26])
            OP_RTYPE: begin
                dec_r = 1'b1;
                case (ir_q[5:0])
                    FN_ADD:  dec_alu = ALU_ADD;
                    FN_SUB:  dec_alu = ALU_SUB;
                    FN_AND:  dec_alu = ALU_AND;
                    FN_OR:   dec_alu = ALU_OR;
                    FN_SLT:  dec_alu = ALU_SLT;
                    default: dec_r   = 1'b0;
                endcase
            end
            OP_ADDI: dec_addi = 1'b1;
            OP_LW:   dec_lw   = 1'b1;
            OP_SW:   dec_sw   = 1'b1;
            OP_BEQ:  dec_beq  = 1'b1;
            OP_J:    dec_j    = 1'b1;
            default: ;
        endcase
        dec_legal = dec_r | dec_addi | dec_lw | dec_sw | dec_beq | dec_j;
    end

    // ALU
    function automatic logic [XLEN-1:0] alu_op(input alu_sel_e sel,
                                               input logic signed [XLEN-1:0] x,
                                               input logic signed [XLEN-1:0] y);
        case (sel)
            ALU_SUB: return x - y;
            ALU_AND: return x & y;
            ALU_OR:  return x | y;
            ALU_SLT: return {{(XLEN-1){1'b0}}, (x < y)};
            default: return x + y;
        endcase
    endfunction

    logic [XLEN-1:0]   rs_val, rt_val, alu_res;
    logic [ADDR_W-1:0] pc_plus4, br_target, j_target;

    assign alu_res   = alu_op(dec_alu, a_q, dec_r ? b_q : imm_q);
    assign pc_plus4  = pc_q + ADDR_W'(4);
    assign br_target = pc_plus4 + ({{(ADDR_W-16){ir_q[15]}}, ir_q[15:0]} << 2);
    assign j_target  = {pc_plus4[ADDR_W-1:28], ir_q[25:0], 2'b00};

    // R-type writes rd; addi and lw write rt.
    cpu_regfile #(.XLEN(XLEN)) u_regfile (
        .clk_i    (clk),
        .rst_ni   (rst),
        .raddr1_i (ir_q[25:21]),
        .raddr2_i (ir_q[20:16]),
        .rdata1_o (rs_val),
        .rdata2_o (rt_val),
        .we_i     (state_q == S_WB),
        .waddr_i  (dec_r ? ir_q[15:11] : ir_q[20:16]),
        .wdata_i  (dec_lw ? mdr_q : alu_q)
    );

    // Control FSM. Every exit toward FETCH raises instr_req in the same edge
    // so the next fetch can be acknowledged without a bubble; only the
    // first fetch after reset spends one cycle raising the request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            imm_q       <= '0;
            alu_q       <= '0;
            mdr_q       <= '0;
            instr_req_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            data_addr_q <= '0;
            data_out_q  <= '0;
            retire_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            retire_q  <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (!instr_req_q) begin
                        instr_req_q <= 1'b1;
                    end else if (instr_ack) begin
                        ir_q        <= instr;
                        instr_req_q <= 1'b0;
                        state_q     <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q     <= rs_val;
                    b_q     <= rt_val;
                    imm_q   <= {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (!dec_legal) begin
                        illegal_q   <= 1'b1;
                        pc_q        <= pc_plus4;
                        instr_req_q <= 1'b1;
                        state_q     <= S_FETCH;
                    end else if (dec_beq || dec_j) begin
                        if (dec_j)
                            pc_q <= j_target;
                        else
                            pc_q <= (a_q == b_q) ? br_target : pc_plus4;
                        retire_q    <= 1'b1;
                        instr_req_q <= 1'b1;
                        state_q     <= S_FETCH;
                    end else if (dec_lw || dec_sw) begin
                        data_addr_q <= alu_res[ADDR_W-1:0];
                        data_out_q  <= b_q;
                        mem_read_q  <= dec_lw;
                        mem_write_q <= dec_sw;
                        state_q     <= S_MEM;
                    end else begin
                        alu_q   <= alu_res;
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (data_ack) begin
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        if (mem_read_q) begin
                            mdr_q   <= data_in;
                            state_q <= S_WB;
                        end else begin
                            pc_q        <= pc_plus4;
                            retire_q    <= 1'b1;
                            instr_req_q <= 1'b1;
                            state_q     <= S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    pc_q        <= pc_plus4;
                    retire_q    <= 1'b1;
                    instr_req_q <= 1'b1;
                    state_q     <= S_FETCH;
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign instr_addr    = pc_q;
    assign instr_req     = instr_req_q;
    assign data_addr     = data_addr_q;
    assign data_out      = data_out_q;
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign retire        = retire_q;
    assign illegal_instr = illegal_q;

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: the bench plays instruction and data
// memory, feeding hand-encoded instructions and observing register contents
// through store data.
module tb_cpu_multicycle;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_addr;
    logic        instr_req;
    logic [31:0] instr;
    logic        instr_ack;
    logic [31:0] data_addr;
    logic [31:0] data_out;
    logic [31:0] data_in;
    logic        mem_read;
    logic        mem_write;
    logic        data_ack;
    logic        retire;
    logic        illegal_instr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_multicycle #(.XLEN(32), .ADDR_W(32), .RESET_PC(32'h80)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_addr    (instr_addr),
        .instr_req     (instr_req),
        .instr         (instr),
        .instr_ack     (instr_ack),
        .data_addr     (data_addr),
        .data_out      (data_out),
        .data_in       (data_in),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .data_ack      (data_ack),
        .retire        (retire),
        .illegal_instr (illegal_instr)
    );

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a fetch request, check its address, ack it zero-wait.
    task automatic fetch(input logic [31:0] w, input logic [31:0] pc, input string tag);
        int n = 0;
        while (instr_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chkb({tag, "_req"}, instr_req, 1'b1);
        chk({tag, "_pc"}, instr_addr, pc);
        instr     = w;
        instr_ack = 1'b1;
        @(negedge clk);
        instr_ack = 1'b0;
        instr     = 32'h0;
    endtask

    // Non-memory instruction; lat counts edges from fetch acceptance to retire.
    task automatic run_alu(input logic [31:0] w, input logic [31:0] pc, input int lat,
                           input string tag);
        fetch(w, pc, tag);
        for (int i = 0; i < lat - 2; i++) begin
            @(negedge clk);
            chkb({tag, "_early_ret"}, retire, 1'b0);
        end
        @(negedge clk);
        chkb({tag, "_retire"}, retire, 1'b1);
        chkb({tag, "_ill"}, illegal_instr, 1'b0);
    endtask

    task automatic do_store(input logic [31:0] w, input logic [31:0] pc, input logic [31:0] addr,
                            input logic [31:0] data, input int delay, input string tag);
        fetch(w, pc, tag);
        @(negedge clk);
        @(negedge clk);
        chkb({tag, "_mw"}, mem_write, 1'b1);
        chkb({tag, "_mr"}, mem_read, 1'b0);
        chk({tag, "_addr"}, data_addr, addr);
        chk({tag, "_data"}, data_out, data);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chkb({tag, "_mw_hold"}, mem_write, 1'b1);
            chk({tag, "_addr_hold"}, data_addr, addr);
            chk({tag, "_data_hold"}, data_out, data);
            chkb({tag, "_early_ret"}, retire, 1'b0);
        end
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        chkb({tag, "_mw_drop"}, mem_write, 1'b0);
        chkb({tag, "_retire"}, retire, 1'b1);
    endtask

    task automatic do_load(input logic [31:0] w, input logic [31:0] pc, input logic [31:0] addr,
                           input logic [31:0] data, input int delay, input string tag);
        fetch(w, pc, tag);
        @(negedge clk);
        @(negedge clk);
        chkb({tag, "_mr"}, mem_read, 1'b1);
        chkb({tag, "_mw"}, mem_write, 1'b0);
        chk({tag, "_addr"}, data_addr, addr);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chkb({tag, "_mr_hold"}, mem_read, 1'b1);
            chkb({tag, "_early_ret"}, retire, 1'b0);
        end
        data_in  = data;
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        data_in  = 32'h0BAD_0BAD;
        chkb({tag, "_mr_drop"}, mem_read, 1'b0);
        chkb({tag, "_wb_ret"}, retire, 1'b0);
        @(negedge clk);
        chkb({tag, "_retire"}, retire, 1'b1);
    endtask

    initial begin
        rst       = 1'b0;
        instr     = 32'h0;
        instr_ack = 1'b0;
        data_in   = 32'h0;
        data_ack  = 1'b0;
        repeat (2) @(negedge clk);

        chkb("rst_instr_req", instr_req, 1'b0);
        chkb("rst_mem_read", mem_read, 1'b0);
        chkb("rst_mem_write", mem_write, 1'b0);
        chkb("rst_retire", retire, 1'b0);
        chkb("rst_illegal", illegal_instr, 1'b0);
        chk("rst_data_addr", data_addr, 32'h0);
        chk("rst_data_out", data_out, 32'h0);
        chk("rst_instr_addr", instr_addr, 32'h80);

        // Release with a stray ack and an illegal word present: must be ignored.
        rst       = 1'b1;
        instr     = 32'hFC00_0000;
        instr_ack = 1'b1;
        @(negedge clk);
        instr_ack = 1'b0;
        chkb("first_req", instr_req, 1'b1);

        run_alu(enc_i(6'h08, 5'd0, 5'd1, 16'd5),      32'h80, 4, "addi_r1");
        run_alu(enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD),   32'h84, 4, "addi_r2");
        run_alu(enc_r(5'd1, 5'd2, 5'd3, 6'h20),       32'h88, 4, "add_r3");
        run_alu(enc_r(5'd1, 5'd2, 5'd4, 6'h22),       32'h8C, 4, "sub_r4");
        run_alu(enc_r(5'd2, 5'd1, 5'd5, 6'h2A),       32'h90, 4, "slt_r5");
        run_alu(enc_r(5'd1, 5'd1, 5'd0, 6'h20),       32'h94, 4, "add_r0");

        do_store(enc_i(6'h2B, 5'd0, 5'd3, 16'h40), 32'h98, 32'h40, 32'h2, 3, "sw_r3");
        do_store(enc_i(6'h2B, 5'd0, 5'd4, 16'h44), 32'h9C, 32'h44, 32'h8, 0, "sw_r4");
        do_store(enc_i(6'h2B, 5'd0, 5'd5, 16'h48), 32'hA0, 32'h48, 32'h1, 0, "sw_r5");
        do_store(enc_i(6'h2B, 5'd0, 5'd0, 16'h4C), 32'hA4, 32'h4C, 32'h0, 0, "sw_r0");

        do_load(enc_i(6'h23, 5'd0, 5'd6, 16'h40), 32'hA8, 32'h40, 32'hDEADBEEF, 3, "lw_r6");
        do_store(enc_i(6'h2B, 5'd0, 5'd6, 16'h50), 32'hAC, 32'h50, 32'hDEADBEEF, 0, "sw_r6");
        do_load(enc_i(6'h23, 5'd0, 5'd7, 16'h54), 32'hB0, 32'h54, 32'h7FFFFFFF, 0, "lw_r7");
        run_alu(enc_i(6'h08, 5'd7, 5'd8, 16'd1),      32'hB4, 4, "addi_wrap");
        do_store(enc_i(6'h2B, 5'd0, 5'd8, 16'h58), 32'hB8, 32'h58, 32'h80000000, 0, "sw_r8");

        run_alu(enc_r(5'd2, 5'd6, 5'd9, 6'h24),       32'hBC, 4, "and_r9");
        run_alu(enc_r(5'd1, 5'd4, 5'd10, 6'h25),      32'hC0, 4, "or_r10");
        do_store(enc_i(6'h2B, 5'd0, 5'd9, 16'h5C),  32'hC4, 32'h5C, 32'hDEADBEED, 0, "sw_r9");
        do_store(enc_i(6'h2B, 5'd0, 5'd10, 16'h60), 32'hC8, 32'h60, 32'h0000000D, 0, "sw_r10");

        run_alu(enc_i(6'h04, 5'd1, 5'd1, 16'hFFFE),   32'hCC, 3, "beq_taken");
        run_alu(enc_i(6'h04, 5'd1, 5'd2, 16'hFFFE),   32'hC8, 3, "beq_not_taken");
        run_alu({6'h02, 26'h100},                     32'hCC, 3, "j_100");

        // Illegal opcode: one pulse, no retire, no write to rt, PC+4.
        fetch(enc_i(6'h3F, 5'd1, 5'd1, 16'd7), 32'h400, "illegal");
        @(negedge clk);
        chkb("illegal_early", illegal_instr, 1'b0);
        @(negedge clk);
        chkb("illegal_pulse", illegal_instr, 1'b1);
        chkb("illegal_no_retire", retire, 1'b0);
        @(negedge clk);
        chkb("illegal_once", illegal_instr, 1'b0);
        do_store(enc_i(6'h2B, 5'd0, 5'd1, 16'h64), 32'h404, 32'h64, 32'h5, 0, "sw_r1");

        // Async reset while a store is waiting in MEM.
        fetch(enc_i(6'h2B, 5'd0, 5'd1, 16'h68), 32'h408, "sw_abort");
        @(negedge clk);
        @(negedge clk);
        chkb("abort_mw_before", mem_write, 1'b1);
        #2 rst = 1'b0;
        #1;
        chkb("abort_mw_dropped", mem_write, 1'b0);
        chkb("abort_req_dropped", instr_req, 1'b0);
        chk("abort_pc", instr_addr, 32'h80);
        chk("abort_data_addr", data_addr, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        do_store(enc_i(6'h2B, 5'd0, 5'd1, 16'h4C), 32'h80, 32'h4C, 32'h0, 0, "sw_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
